// File: rtl/fir_serial_mac.sv
// Serial-MAC FIR filter: TAPS-entry circular sample buffer and coefficient RAM
// sharing one multiplier and one accumulator.
// Latency: output pulse TAPS+1 cycles after a sample is accepted; one sample per TAPS+2 cycles.
// Backpressure: in_ready is high only in IDLE; the source must hold the sample until accepted.
// Ports:
//   clk, rst                        clock and synchronous active-high reset
//   in_data/in_valid/in_ready       sample input handshake (signed DW)
//   coef_wr/coef_addr/coef_data     coefficient write port, honoured only in IDLE
//   out_data/out_valid              result (signed DW, held between pulses) and one-cycle strobe
//   busy                            high while a sample is being processed
module fir_serial_mac #(
  parameter int DW     = 16,
  parameter int CW     = 16,
  parameter int TAPS   = 21,
  parameter int OSHIFT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     coef_wr,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [CW-1:0]            coef_data,
  output logic [DW-1:0]            out_data,
  output logic                     out_valid,
  output logic                     busy
);

  localparam int AW  = $clog2(TAPS);
  localparam int PW  = DW + CW;
  localparam int ACW = PW + AW;

  localparam logic [AW-1:0] LAST  = AW'(TAPS - 1);
  localparam logic [AW:0]   NTAPS = (AW + 1)'(TAPS);

  // Rounding constant 2^(OSHIFT-1); evaluates to zero when OSHIFT is 0.
  localparam logic [ACW:0]        ONE  = (ACW + 1)'(1);
  localparam logic signed [ACW:0] RND  = $signed((ONE << OSHIFT) >> 1);
  localparam logic signed [ACW:0] SMAX = $signed({{(ACW + 2 - DW){1'b0}}, {(DW - 1){1'b1}}});
  localparam logic signed [ACW:0] SMIN = $signed({{(ACW + 2 - DW){1'b1}}, {(DW - 1){1'b0}}});

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                 state;
  logic signed [DW-1:0]   sbuf [TAPS];
  logic signed [CW-1:0]   coef [TAPS];
  logic [AW-1:0]          wptr;   // oldest entry, overwritten by the next sample
  logic [AW-1:0]          rptr;   // x[n-k] for the current tap
  logic [AW-1:0]          k;
  logic signed [ACW-1:0]  acc;

  logic signed [PW-1:0]   prod;
  logic signed [ACW-1:0]  acc_next;
  logic signed [ACW:0]    rnd;
  logic signed [ACW:0]    shifted;
  logic [DW-1:0]          sat_data;
  logic [AW-1:0]          wptr_inc;
  logic [AW-1:0]          rptr_dec;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Pointers wrap explicitly so non-power-of-two TAPS works.
  assign wptr_inc = (wptr == LAST) ? '0 : wptr + AW'(1);
  assign rptr_dec = (rptr == '0) ? LAST : rptr - AW'(1);

  always_comb begin
    prod     = PW'(sbuf[rptr]) * PW'(coef[k]);
    acc_next = acc + $signed({{AW{prod[PW-1]}}, prod});
    // One guard bit so the rounding add cannot wrap.
    rnd      = $signed({acc_next[ACW-1], acc_next}) + RND;
    shifted  = rnd >>> OSHIFT;
    if (shifted > SMAX) begin
      sat_data = {1'b0, {(DW - 1){1'b1}}};
    end else if (shifted < SMIN) begin
      sat_data = {1'b1, {(DW - 1){1'b0}}};
    end else begin
      sat_data = shifted[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      acc       <= '0;
      wptr      <= '0;
      rptr      <= '0;
      k         <= '0;
      for (int i = 0; i < TAPS; i++) begin
        sbuf[i] <= '0;
        coef[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Coefficients only change here, so one output never mixes old and new sets.
          if (coef_wr && ({1'b0, coef_addr} < NTAPS)) begin
            coef[coef_addr] <= coef_data;
          end
          if (in_valid) begin
            sbuf[wptr] <= in_data;
            rptr       <= wptr;
            wptr       <= wptr_inc;
            acc        <= '0;
            k          <= '0;
            state      <= MAC;
          end
        end
        MAC: begin
          acc  <= acc_next;
          rptr <= rptr_dec;
          if (k == LAST) begin
            // Final tap: the result is formed from acc_next so out_valid lands in OUT.
            out_data  <= sat_data;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            k <= k + AW'(1);
          end
        end
        OUT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Directed testbench for fir_serial_mac: impulse response, saturation,
// coefficient write guard, reset abort, continuous backpressure and pointer wrap (TAPS=5).
module tb_fir_serial_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic               coef_wr;
  logic [4:0]         coef_addr;
  logic [15:0]        coef_data;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               busy;

  logic signed [15:0] b_in_data;
  logic               b_in_valid;
  logic               b_in_ready;
  logic               b_coef_wr;
  logic [2:0]         b_coef_addr;
  logic [19:0]        b_coef_data;
  logic signed [15:0] b_out_data;
  logic               b_out_valid;
  logic               b_busy;

  fir_serial_mac #(.DW(16), .CW(16), .TAPS(21), .OSHIFT(15)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_data(out_data), .out_valid(out_valid), .busy(busy)
  );

  fir_serial_mac #(.DW(16), .CW(20), .TAPS(5), .OSHIFT(15)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .coef_wr(b_coef_wr), .coef_addr(b_coef_addr), .coef_data(b_coef_data),
    .out_data(b_out_data), .out_valid(b_out_valid), .busy(b_busy)
  );

  typedef struct {
    int x;
    int y;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic write_coef(input int addr, input int data);
    logic [31:0] a;
    logic [31:0] d;
    a = addr;
    d = data;
    wait_ready();
    coef_wr   = 1'b1;
    coef_addr = a[4:0];
    coef_data = d[15:0];
    tick();
    coef_wr = 1'b0;
  endtask

  // Waits for the output pulse of an already-accepted sample; we are in cycle T+1 on entry.
  task automatic wait_out(output int y, output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (out_valid) begin
      y = int'(out_data);
    end else begin
      y   = 99999;
      lat = -1;
    end
  endtask

  task automatic send(input int d, output int y, output int lat);
    logic [31:0] v;
    v = d;
    wait_ready();
    in_valid = 1'b1;
    in_data  = v[15:0];
    tick();
    in_valid = 1'b0;
    coef_wr  = 1'b0;
    wait_out(y, lat);
  endtask

  task automatic send_b(input int d, output int y, output int lat);
    logic [31:0] v;
    int n;
    v = d;
    n = 0;
    while (!b_in_ready && n < 100) begin
      tick();
      n++;
    end
    b_in_valid = 1'b1;
    b_in_data  = v[15:0];
    tick();
    b_in_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (b_out_valid) begin
      y = int'(b_out_data);
    end else begin
      y   = 99999;
      lat = -1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t imp [21];
    vec_t wrap [12];
    int   y, lat, held, cnt;

    imp[0] = '{16384, 128};
    for (int i = 1; i < 21; i++) imp[i] = '{0, 128 * (i + 1)};
    wrap = '{'{1, 1}, '{2, 2}, '{3, 5}, '{4, 10}, '{5, 18}, '{6, 25},
             '{7, 33}, '{8, 40}, '{9, 48}, '{10, 55}, '{11, 63}, '{12, 70}};

    rst = 1'b1;
    in_data = '0; in_valid = 1'b0; coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
    b_in_data = '0; b_in_valid = 1'b0; b_coef_wr = 1'b0; b_coef_addr = '0; b_coef_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);

    // Impulse response with h[k] = 256*(k+1).
    for (int k = 0; k < 21; k++) write_coef(k, 256 * (k + 1));
    for (int i = 0; i < 21; i++) begin
      send(imp[i].x, y, lat);
      check($sformatf("impulse_y[%0d]", i), y, imp[i].y);
      check($sformatf("impulse_lat[%0d]", i), lat, 22);
      if (i == 0) begin
        held = y;
        tick();
        check("pulse_one_cycle", int'(out_valid), 0);
        repeat (3) tick();
        check("out_data_held", int'(out_data), held);
      end
    end

    // Saturation.
    for (int k = 0; k < 21; k++) write_coef(k, 32767);
    for (int i = 0; i < 21; i++) begin
      send(32767, y, lat);
      if (i == 0) check("sat_first_pos", y, 32766);
    end
    check("sat_pos", y, 32767);
    for (int i = 0; i < 21; i++) send(-32768, y, lat);
    check("sat_neg", y, -32768);

    // Coefficient write guard: out-of-range address and writes during MAC are dropped.
    write_coef(0, 16'h2000);
    for (int k = 1; k < 21; k++) write_coef(k, 0);
    write_coef(21, 16'h7FFF);
    wait_ready();
    in_valid = 1'b1;
    in_data  = '0;
    tick();
    in_valid = 1'b0;
    check("mac_busy", int'(busy), 1);
    check("mac_in_ready", int'(in_ready), 0);
    repeat (2) tick();
    coef_wr   = 1'b1;
    coef_addr = 5'd0;
    coef_data = 16'h1000;
    tick();
    coef_wr = 1'b0;
    wait_out(y, lat);
    check("guard_zero_y", y, 0);
    send(16384, y, lat);
    check("guard_old_h0", y, 4096);

    // Coefficient write and sample acceptance in the same IDLE cycle.
    wait_ready();
    coef_wr   = 1'b1;
    coef_addr = 5'd0;
    coef_data = 16'h0800;
    send(16384, y, lat);
    check("same_cycle_coef", y, 1024);

    // Reset at T+5 aborts the computation and clears the coefficients.
    wait_ready();
    in_valid = 1'b1;
    in_data  = 16'sh4000;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_out_data", int'(out_data), 0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) cnt++;
      tick();
    end
    check("rst_no_out_valid", cnt, 0);
    send(16384, y, lat);
    check("rst_coef_zero_y", y, 0);
    check("rst_lat", lat, 22);

    // Continuous in_valid: h[0] = 0x4000 gives y = x/2 for even x.
    write_coef(0, 16'h4000);
    wait_ready();
    begin
      int q[$];
      int nxt = 2;
      int acc_cnt = 0;
      int ov_cnt = 0;
      int last_rdy = -1;
      int gap_bad = 0;
      int extra = 0;
      bit took;
      in_valid = 1'b1;
      in_data  = 16'(nxt);
      for (int c = 0; c < 150; c++) begin
        took = 1'b0;
        if (c < 120 && in_ready) begin
          if (last_rdy >= 0 && c - last_rdy != 23) gap_bad++;
          last_rdy = c;
          q.push_back(nxt / 2);
          acc_cnt++;
          took = 1'b1;
        end
        if (out_valid) begin
          ov_cnt++;
          if (q.size() == 0) extra++;
          else check("bp_data", int'(out_data), q.pop_front());
        end
        if (c == 119) in_valid = 1'b0;
        tick();
        if (took) begin
          nxt += 2;
          in_data = 16'(nxt);
        end
      end
      check("bp_gap_23", gap_bad, 0);
      check("bp_accepted", acc_cnt, 6);
      check("bp_one_out_per_in", ov_cnt, acc_cnt);
      check("bp_no_extra", extra, 0);
      check("bp_none_lost", q.size(), 0);
    end

    // Pointer wrap on the TAPS=5 instance, h[k] = (k+1)*0x4000.
    for (int k = 0; k < 5; k++) begin
      b_coef_wr   = 1'b1;
      b_coef_addr = 3'(k);
      b_coef_data = 20'((k + 1) * 16384);
      tick();
    end
    b_coef_wr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      send_b(wrap[i].x, y, lat);
      check($sformatf("wrap_y[%0d]", i), y, wrap[i].y);
      if (i == 0) check("wrap_lat", lat, 6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_serial_mac.md
FIR_SERIAL_MAC -- requirements
Module: fir_serial_mac

Interface
REQ-001 Parameter DW, default 16, signed two's-complement sample width for both in and out.
REQ-002 Parameter CW, default 16, signed coefficient width.
REQ-003 Parameter TAPS, default 21, number of taps; legal range 2..256.
REQ-004 Parameter OSHIFT, default 15, right-shift applied to the accumulator before output (Q-format alignment).
REQ-005 clk  in  1  sole clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 in_data  in  DW  input sample, signed.
REQ-008 in_valid  in  1  in_data is valid this cycle.
REQ-009 in_ready  out  1  block can accept a sample this cycle.
REQ-010 coef_wr  in  1  coefficient write strobe.
REQ-011 coef_addr  in  clog2(TAPS)  tap index k of the coefficient being written.
REQ-012 coef_data  in  CW  coefficient h[k], signed.
REQ-013 out_data  out  DW  filtered sample, signed.
REQ-014 out_valid  out  1  one-cycle pulse; out_data is valid.
REQ-015 busy  out  1  high while a sample is being processed (state MAC or OUT).

Function
REQ-016 Output SHALL be y[n] = sat(round((sum over k=0..TAPS-1 of h[k]*x[n-k]) >>> OSHIFT)).
REQ-017 Storage SHALL be a TAPS-entry circular sample buffer plus a TAPS-entry coefficient RAM, processed by one multiplier and one accumulator.
REQ-018 Accumulator width SHALL be DW+CW+clog2(TAPS); no overflow is possible inside the sum.
REQ-019 FSM states SHALL be IDLE, MAC and OUT; reset state is IDLE.
REQ-020 in_ready SHALL equal (state==IDLE); a sample is accepted on a cycle T with in_valid and in_ready both high.
REQ-021 On acceptance the sample SHALL overwrite the oldest buffer entry, the accumulator SHALL clear, the tap counter SHALL go to 0, and the state SHALL go to MAC.
REQ-022 In MAC, each cycle SHALL add h[k]*x[n-k] for the current k and then increment k.
REQ-023 After k = TAPS-1 is accumulated (cycle T+TAPS), the state SHALL go to OUT.
REQ-024 In OUT (cycle T+TAPS+1), out_valid SHALL be 1 with out_data valid; the next state SHALL be IDLE.
REQ-025 Latency from acceptance to output SHALL be TAPS+1 cycles; maximum throughput is one sample per TAPS+2 cycles.
REQ-026 in_valid while not in IDLE SHALL be ignored; the sample is not stored, and the upstream source holds it until in_ready is high.
REQ-027 Rounding SHALL be round-half-up: add 2^(OSHIFT-1) before the arithmetic shift (no add when OSHIFT=0).
REQ-028 Saturation: a shifted result above 2^(DW-1)-1 SHALL clamp to 2^(DW-1)-1; below -2^(DW-1) it SHALL clamp to -2^(DW-1).
REQ-029 coef_wr SHALL be honoured only in IDLE; writes in MAC or OUT SHALL be dropped, so coefficients stay stable within one output.
REQ-030 A coef_wr with coef_addr >= TAPS SHALL be ignored.
REQ-031 coef_wr and sample acceptance in the same IDLE cycle SHALL both take effect, and the new coefficient SHALL be used for that sample.
REQ-032 Buffer read/write pointers SHALL wrap modulo TAPS, including non-power-of-two TAPS.
REQ-033 out_data SHALL hold its last value between out_valid pulses.

Reset
REQ-034 On rst: state=IDLE, in_ready=1, busy=0, out_valid=0, out_data=0, accumulator=0, buffer pointer=0.
REQ-035 On rst: all sample-buffer entries=0 and all coefficients=0.
REQ-036 rst asserted mid-MAC SHALL abort the computation; no out_valid SHALL follow.

Verification (DW=16, CW=16, TAPS=21, OSHIFT=15)
REQ-037 Impulse: load h[k]=256*(k+1), feed 0x4000 then 20 zeros, one sample per 23 cycles -> the 21 outputs are 128*(k+1) (128, 256, ..., 2688), each exactly 22 cycles after acceptance.
REQ-038 Saturation: all h=0x7FFF, 21 samples of 0x7FFF -> last output 0x7FFF; then 21 samples of 0x8000 -> last output 0x8000.
REQ-039 Backpressure: in_valid held high continuously -> in_ready high 1 cycle in every 23; exactly one out_valid per accepted sample; no sample lost or duplicated.
REQ-040 Coefficient write guard: coef_wr addr=0 data=0x1000 during MAC, then impulse 0x4000 -> first output equals the old h[0]/2; coef_addr=21 is ignored.
REQ-041 Reset mid-operation: rst for 1 cycle at T+5 after acceptance -> no out_valid; coefficients=0; next impulse gives output 0.
REQ-042 Wrap: TAPS=5, h={1,2,3,4,5}*0x4000, ramp input 1..12 -> outputs match a reference model across pointer wrap.
